// File: rtl/scara_fx_pkg.sv
// scara_fx_pkg: shared fixed-point types, FSM states and W-bit saturation for the SCARA datapath.
package scara_fx_pkg;
    localparam int FX_W     = 32;
    localparam int FX_FRAC  = 16;
    localparam int SAT_IN_W = 128;
    typedef logic signed [FX_W-1:0] fx_t;
    typedef enum logic [2:0] {IDLE, MULT, DET, RECIP, SCALE, DONE} jinv_state_e;
    localparam fx_t FX_ONE = fx_t'(1 << FX_FRAC);
    localparam logic signed [SAT_IN_W-1:0] SAT_ONE = SAT_IN_W'(1);
    // Clip a wide signed value into the signed w-bit range.
    function automatic logic signed [SAT_IN_W-1:0] sat_w(input logic signed [SAT_IN_W-1:0] x, input int w);
        logic signed [SAT_IN_W-1:0] lim;
        lim = '0;
        lim[w-1] = 1'b1;
        return (x >= lim) ? lim - SAT_ONE : (x < -lim) ? -lim : x;
    endfunction
endpackage

// File: rtl/fx_recip_div.sv
// fx_recip_div: unsigned restoring divider of 1<<2*FRAC by divisor, W+FRAC iterations, first on start.
module fx_recip_div #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [W-1:0]        divisor,
    output logic [W+FRAC-1:0]   quotient,
    output logic                overflow,
    output logic                done
);
    localparam int Q  = W + FRAC;
    localparam int CW = $clog2(Q);
    localparam logic [Q-1:0] NUM = Q'(1) << (2 * FRAC);
    logic [W-1:0]  rem, rem_in, dvs, dvs_in;
    logic [Q-1:0]  quo_in;
    logic [W:0]    shifted;
    logic          ge;
    logic [CW-1:0] cnt;
    always_comb begin
        rem_in  = start ? '0 : rem;
        quo_in  = start ? NUM : quotient;
        dvs_in  = start ? divisor : dvs;
        shifted = {rem_in, quo_in[Q-1]};
        ge      = shifted >= {1'b0, dvs_in};
    end
    // The start edge performs the first iteration so the whole division spans exactly Q edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem      <= '0;
            quotient <= '0;
            dvs      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else if (start || cnt != '0) begin
            rem      <= ge ? W'(shifted - {1'b0, dvs_in}) : W'(shifted);
            quotient <= {quo_in[Q-2:0], ge};
            dvs      <= dvs_in;
            cnt      <= start ? CW'(Q - 1) : cnt - CW'(1);
            done     <= !start && cnt == CW'(1);
        end
    end
    assign overflow = |quotient[Q-1:W];
endmodule

// File: rtl/jacobian_inverse_fx.sv
// jacobian_inverse_fx: fixed-point 2x2 inverse with handshakes, singularity detection and saturation.
module jacobian_inverse_fx import scara_fx_pkg::*; #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int DET_EPS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] aOut,
    output logic signed [W-1:0] bOut_n,
    output logic signed [W-1:0] cOut_n,
    output logic signed [W-1:0] dOut,
    output logic                singular,
    output logic                saturated
);
    localparam int P = 2 * W + 1;
    localparam int Q = W + FRAC;
    localparam logic signed [SAT_IN_W-1:0] EPS = SAT_IN_W'(DET_EPS);
    function automatic logic signed [2*W-1:0] ext_2w(input logic signed [W-1:0] x);
        return {{W{x[W-1]}}, x};
    endfunction
    function automatic logic signed [P-1:0] ext_p(input logic signed [W:0] x);
        return {{(P-W-1){x[W]}}, x};
    endfunction
    function automatic logic signed [SAT_IN_W-1:0] xw_p(input logic signed [P-1:0] x);
        return {{(SAT_IN_W-P){x[P-1]}}, x};
    endfunction
    jinv_state_e state, state_nx;
    logic signed [W-1:0]        a_r, b_r, c_r, d_r, r_r, det_w;
    logic signed [2*W-1:0]      ad_r, bc_r;
    logic signed [P-1:0]        diff, det_sh;
    logic signed [SAT_IN_W-1:0] det_x, rec_x, rec_s, qx;
    logic [W-1:0]               det_mag;
    logic [Q-1:0]               div_q;
    logic                       det_clip, det_sing, det_neg, rec_clip, sat_acc;
    logic                       div_start, div_done, div_ovf;
    logic signed [W:0]          op [4];
    logic signed [P-1:0]        prod_sh [4];
    logic signed [SAT_IN_W-1:0] sc [4];
    logic [3:0]                 clip;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    // Determinant: difference kept at 2W+1 bits so ad-bc never wraps before the floor shift.
    always_comb begin
        diff      = {ad_r[2*W-1], ad_r} - {bc_r[2*W-1], bc_r};
        det_sh    = diff >>> FRAC;
        det_x     = sat_w(xw_p(det_sh), W);
        det_clip  = det_x != xw_p(det_sh);
        det_w     = det_x[W-1:0];
        det_mag   = det_w[W-1] ? -det_w : det_w;
        det_sing  = (det_x <= EPS) && (det_x >= -EPS);
        div_start = (state == DET) && !det_sing;
        qx        = {{(SAT_IN_W-Q){1'b0}}, div_q};
        rec_x     = det_neg ? -qx : qx;
        rec_s     = sat_w(rec_x, W);
        rec_clip  = div_ovf | (rec_s != rec_x);
    end
    always_comb begin
        op[0] = {d_r[W-1], d_r};
        op[1] = -{b_r[W-1], b_r};
        op[2] = -{c_r[W-1], c_r};
        op[3] = {a_r[W-1], a_r};
        for (int i = 0; i < 4; i++) begin
            prod_sh[i] = (ext_p(op[i]) * ext_p({r_r[W-1], r_r})) >>> FRAC;
            sc[i]      = sat_w(xw_p(prod_sh[i]), W);
            clip[i]    = sc[i] != xw_p(prod_sh[i]);
        end
    end
    fx_recip_div #(.W(W), .FRAC(FRAC)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .divisor  (det_mag),
        .quotient (div_q),
        .overflow (div_ovf),
        .done     (div_done)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? MULT : IDLE;
            MULT:    state_nx = DET;
            DET:     state_nx = det_sing ? DONE : RECIP;
            RECIP:   state_nx = div_done ? SCALE : RECIP;
            SCALE:   state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {a_r, b_r, c_r, d_r, r_r} <= '0;
            {ad_r, bc_r}              <= '0;
            {aOut, bOut_n, cOut_n, dOut} <= '0;
            {singular, saturated, sat_acc, det_neg} <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_r <= a;
                b_r <= b;
                c_r <= c;
                d_r <= d;
            end
            if (state == MULT) begin
                ad_r <= ext_2w(a_r) * ext_2w(d_r);
                bc_r <= ext_2w(b_r) * ext_2w(c_r);
            end
            if (state == DET) begin
                det_neg <= det_w[W-1];
                sat_acc <= det_clip;
                if (det_sing) begin
                    {aOut, bOut_n, cOut_n, dOut} <= '0;
                    singular  <= 1'b1;
                    saturated <= 1'b0;
                end
            end
            if (state == RECIP && div_done) begin
                r_r     <= rec_s[W-1:0];
                sat_acc <= sat_acc | rec_clip;
            end
            if (state == SCALE) begin
                aOut      <= sc[0][W-1:0];
                bOut_n    <= sc[1][W-1:0];
                cOut_n    <= sc[2][W-1:0];
                dOut      <= sc[3][W-1:0];
                singular  <= 1'b0;
                saturated <= sat_acc | (|clip);
            end
        end
    end
endmodule

// File: tb/tb_jacobian_inverse_fx.sv
// tb_jacobian_inverse_fx: directed and random matrices checked against an arithmetic inverse model.
module tb_jacobian_inverse_fx;
    import scara_fx_pkg::*;
    localparam int W = 32, FRAC = 16, DET_EPS = 16;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (W - 1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (W - 1));
    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, singular, saturated;
    fx_t a = '0, b = '0, c = '0, d = '0;
    fx_t aOut, bOut_n, cOut_n, dOut;
    fx_t exp_o [4];
    logic exp_sing, exp_sat;
    int exp_lat;
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    jacobian_inverse_fx #(.W(W), .FRAC(FRAC), .DET_EPS(DET_EPS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .aOut(aOut), .bOut_n(bOut_n), .cOut_n(cOut_n), .dOut(dOut),
        .singular(singular), .saturated(saturated)
    );
    function automatic logic signed [127:0] clip(input logic signed [127:0] x);
        return x > MAXV ? MAXV : x < MINV ? MINV : x;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    // Inverse from first principles: det, reciprocal and scaled adjugate in wide integers.
    task automatic model(input fx_t ia, input fx_t ib, input fx_t ic, input fx_t id);
        logic signed [127:0] det, r, v;
        logic signed [127:0] x [4];
        logic s;
        det = (128'(ia) * 128'(id) - 128'(ib) * 128'(ic)) >>> FRAC;
        s = clip(det) != det;
        det = clip(det);
        exp_sing = det <= 128'(DET_EPS) && det >= -128'(DET_EPS);
        if (exp_sing) begin
            for (int i = 0; i < 4; i++) exp_o[i] = '0;
            exp_sat = 1'b0;
            exp_lat = 2;
        end else begin
            r = (128'sd1 <<< (2 * FRAC)) / det;
            s = s | (clip(r) != r);
            r = clip(r);
            x[0] = 128'(id);
            x[1] = -128'(ib);
            x[2] = -128'(ic);
            x[3] = 128'(ia);
            for (int i = 0; i < 4; i++) begin
                v = (x[i] * r) >>> FRAC;
                s = s | (clip(v) != v);
                exp_o[i] = fx_t'(clip(v));
            end
            exp_sat = s;
            exp_lat = W + FRAC + 3;
        end
    endtask
    task automatic run(input fx_t ia, input fx_t ib, input fx_t ic, input fx_t id, input int hold);
        int lat;
        model(ia, ib, ic, id);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        a = ia; b = ib; c = ic; d = id;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = fx_t'($urandom); b = fx_t'($urandom); c = fx_t'($urandom); d = fx_t'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("aOut", aOut, exp_o[0]);
        chk("bOut_n", bOut_n, exp_o[1]);
        chk("cOut_n", cOut_n, exp_o[2]);
        chk("dOut", dOut, exp_o[3]);
        chk("singular", 32'(singular), 32'(exp_sing));
        chk("saturated", 32'(saturated), 32'(exp_sat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_aOut", aOut, exp_o[0]);
            chk("hold_cOut_n", cOut_n, exp_o[2]);
            chk("hold_flags", {30'b0, singular, saturated}, {30'b0, exp_sing, exp_sat});
            in_valid = 1'($urandom_range(0, 1));
            a = fx_t'($urandom);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_dropped", 32'(out_valid), 0);
        chk("ready_after", 32'(in_ready), 1);
    endtask
    initial begin
        fx_t ra, rb, rc, rd;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_aOut", aOut, 0);
        chk("rst_flags", {30'b0, singular, saturated}, 0);
        @(negedge clk);
        reset = 1'b1;
        run(FX_ONE, 0, 0, FX_ONE, 0);
        run(32'h0002_0000, 0, 0, 32'h0004_0000, 0);
        run(0, FX_ONE, FX_ONE, 0, 0);
        run(FX_ONE, 32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 0);
        run(32'h0001_8000, 32'h0000_4000, 32'hFFFF_0000, 32'h0002_0000, 10);
        run(0, 0, 0, 0, 3);
        run(FX_ONE, 0, 0, FX_ONE, 10);
        @(negedge clk);
        a = 32'h0003_0000; b = 0; c = 0; d = 32'h0003_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(in_ready), 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_aOut", aOut, 0);
        chk("mid_rst_dOut", dOut, 0);
        chk("mid_rst_flags", {30'b0, singular, saturated}, 0);
        @(negedge clk);
        reset = 1'b1;
        run(FX_ONE, 0, 0, FX_ONE, 0);
        run(32'h0010_0000, 0, 32'h0020_0000, 32'h0000_0002, 0);
        run(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        for (int k = 0; k < 24; k++) begin
            case (k % 3)
                0: begin
                    ra = fx_t'($urandom); rb = fx_t'($urandom);
                    rc = fx_t'($urandom); rd = fx_t'($urandom);
                end
                1: begin
                    ra = fx_t'(int'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000);
                    rb = fx_t'(int'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000);
                    rc = fx_t'(int'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000);
                    rd = fx_t'(int'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000);
                end
                default: begin
                    ra = fx_t'(int'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000);
                    rb = fx_t'(int'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000);
                    rc = ra;
                    rd = rb + fx_t'(int'($urandom_range(0, 64)) - 32);
                end
            endcase
            run(ra, rb, rc, rd, int'($urandom_range(0, 2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
